// File: rtl/instr_sequencer.sv
// Program-memory instruction sequencer: issues stored words to the ALU either
// free-running every DIV cycles or one at a time under single-step control.
module instr_sequencer #(
    parameter int unsigned          Taminstr  = 8,
    parameter int unsigned          DEPTH     = 16,
    parameter int unsigned          DIV       = 4,
    parameter logic [Taminstr-1:0]  HALT_WORD = 8'hFF,
    localparam int unsigned         PW        = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [PW-1:0]       wr_addr,
    input  logic [Taminstr-1:0] wr_data,
    input  logic                start,
    input  logic                step_mode,
    input  logic                step,
    output logic [Taminstr-1:0] instrucciones,
    output logic                instr_valid,
    output logic [PW-1:0]       pc,
    output logic                busy,
    output logic                done
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV - 1);
    localparam logic [PW-1:0] LAST_PC  = PW'(DEPTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [Taminstr-1:0] mem [DEPTH];

    logic [2:0]          state_q, state_d;
    logic [PW-1:0]       pc_q, pc_d;
    logic [Taminstr-1:0] instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                mem_we;
    logic [Taminstr-1:0] cur_word;

    assign cur_word = mem[pc_q];

    // Program store; deliberately has no reset so a program survives reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        done_d  = done_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                mem_we = wr_en;
                if (start) begin
                    pc_d    = '0;
                    done_d  = 1'b0;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (cur_word == HALT_WORD) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    instr_d = cur_word;
                    valid_d = 1'b1;
                    cnt_d   = DIV_LOAD;
                    // The last slot ends the program; there is no wrap-around run.
                    if (pc_q == LAST_PC) begin
                        pc_d    = '0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        pc_d = pc_q + PW'(1);
                        if (step_mode) begin
                            state_d = S_PAUSE;
                        end else if (DIV == 1) begin
                            state_d = S_ISSUE;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
            end

            S_WAIT: begin
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            S_PAUSE: begin
                if (step || !step_mode) begin
                    state_d = S_ISSUE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_PAUSE);
    end

    assign instrucciones = instr_q;
    assign instr_valid   = valid_q;
    assign pc            = pc_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a DIV=4 instance for the general cases
// and a DIV=1 instance for back-to-back issue, both on shared inputs.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       start, step_mode, step;

    logic [7:0] instr_a, instr_b;
    logic       valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    logic [3:0] pc_a, pc_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_sequencer #(.Taminstr(8), .DEPTH(16), .DIV(4), .HALT_WORD(8'hFF)) u_a (
        .clk(clk), .reset(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .step_mode(step_mode), .step(step),
        .instrucciones(instr_a), .instr_valid(valid_a), .pc(pc_a), .busy(busy_a), .done(done_a)
    );

    instr_sequencer #(.Taminstr(8), .DEPTH(16), .DIV(1), .HALT_WORD(8'hFF)) u_b (
        .clk(clk), .reset(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .step_mode(step_mode), .step(step),
        .instrucciones(instr_b), .instr_valid(valid_b), .pc(pc_b), .busy(busy_b), .done(done_b)
    );

    typedef struct {
        logic       start;
        logic       sm;
        logic       step;
        logic       valid;
        logic [7:0] instr;
        logic       busy;
        logic       done;
        logic [3:0] pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input logic sm, input logic sp, input logic v,
                                input logic [7:0] i, input logic b, input logic d,
                                input logic [3:0] p);
        vec_t r;
        r.start = st; r.sm = sm; r.step = sp; r.valid = v;
        r.instr = i;  r.busy = b; r.done = d; r.pc = p;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic write_mem(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_basic();
        write_mem(4'd0, 8'h12);
        write_mem(4'd1, 8'h34);
        write_mem(4'd2, 8'h56);
        write_mem(4'd3, 8'hFF);
    endtask

    task automatic check_a(input string tag, input logic v, input logic [7:0] i,
                           input logic b, input logic d, input logic [3:0] p);
        check({tag, ".valid"}, 32'(valid_a), 32'(v));
        check({tag, ".instr"}, 32'(instr_a), 32'(i));
        check({tag, ".busy"},  32'(busy_a),  32'(b));
        check({tag, ".done"},  32'(done_a),  32'(d));
        check({tag, ".pc"},    32'(pc_a),    32'(p));
    endtask

    task automatic run_rows(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            start = tbl[i].start; step_mode = tbl[i].sm; step = tbl[i].step;
            tick();
            start = 1'b0; step = 1'b0;
            check_a($sformatf("%s[%0d]", tag, i - lo), tbl[i].valid, tbl[i].instr,
                    tbl[i].busy, tbl[i].done, tbl[i].pc);
        end
        step_mode = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; step_mode = 1'b0; step = 1'b0;

        // Free-run, DIV=4: rows 0..14 (row 0 carries the start pulse)
        tbl.push_back(mk(1,0,0, 0,8'h00,1,0,4'd0));
        tbl.push_back(mk(0,0,0, 1,8'h12,1,0,4'd1));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0,0,0, 0,8'h12,1,0,4'd1));
        tbl.push_back(mk(0,0,0, 1,8'h34,1,0,4'd2));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0,0,0, 0,8'h34,1,0,4'd2));
        tbl.push_back(mk(0,0,0, 1,8'h56,1,0,4'd3));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0,0,0, 0,8'h56,1,0,4'd3));
        tbl.push_back(mk(0,0,0, 0,8'h56,0,1,4'd3));
        tbl.push_back(mk(0,0,0, 0,8'h56,0,1,4'd3));
        // Single-step: rows 15..28; step_mode dropped in PAUSE at row 25
        tbl.push_back(mk(1,1,0, 0,8'h00,1,0,4'd0));
        tbl.push_back(mk(0,1,0, 1,8'h12,1,0,4'd1));
        tbl.push_back(mk(0,1,0, 0,8'h12,1,0,4'd1));
        tbl.push_back(mk(0,1,0, 0,8'h12,1,0,4'd1));
        tbl.push_back(mk(0,1,1, 0,8'h12,1,0,4'd1));
        tbl.push_back(mk(0,1,0, 1,8'h34,1,0,4'd2));
        tbl.push_back(mk(0,1,0, 0,8'h34,1,0,4'd2));
        tbl.push_back(mk(0,1,0, 0,8'h34,1,0,4'd2));
        tbl.push_back(mk(0,1,1, 0,8'h34,1,0,4'd2));
        tbl.push_back(mk(0,1,0, 1,8'h56,1,0,4'd3));
        tbl.push_back(mk(0,0,0, 0,8'h56,1,0,4'd3));
        tbl.push_back(mk(0,0,0, 0,8'h56,0,1,4'd3));
        tbl.push_back(mk(0,0,1, 0,8'h56,0,1,4'd3));
        tbl.push_back(mk(0,0,0, 0,8'h56,0,1,4'd3));

        // Reset state
        tick();
        check_a("reset", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
        check("reset.b_busy", 32'(busy_b), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic free-run program
        load_basic();
        run_rows(0, 14, "free");

        // Single-step
        do_reset();
        run_rows(15, 28, "step");

        // Async reset mid-WAIT, then rerun with memory intact
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("rst.pre_valid", 32'(valid_a), 32'd1);
        check("rst.pre_instr", 32'(instr_a), 32'h34);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_a("rst.async", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rst.idle%0d.valid", k), 32'(valid_a), 32'd0);
            check($sformatf("rst.idle%0d.busy", k),  32'(busy_a),  32'd0);
        end
        run_rows(0, 14, "rerun");

        // Writes and start ignored while busy; start with write taken in DONE
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check("busy.first", 32'(instr_a), 32'h12);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hAA; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        tick(); tick(); tick();
        check("busy.second_valid", 32'(valid_a), 32'd1);
        check("busy.second_instr", 32'(instr_a), 32'h34);
        check("busy.second_pc",    32'(pc_a),    32'd2);
        for (int k = 0; k < 8; k++) tick();
        check("busy.done",  32'(done_a),  32'd1);
        check("busy.idle",  32'(busy_a),  32'd0);
        check("busy.hold",  32'(instr_a), 32'h56);
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'h77; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        check_a("wrstart.e0", 1'b0, 8'h56, 1'b1, 1'b0, 4'd0);
        tick();
        check_a("wrstart.e1", 1'b1, 8'h12, 1'b1, 1'b0, 4'd1);
        tick(); tick(); tick(); tick();
        check_a("wrstart.e5", 1'b1, 8'h77, 1'b1, 1'b0, 4'd2);

        // Halt in slot 0: nothing issued, done two cycles after start
        do_reset();
        write_mem(4'd0, 8'hFF);
        start = 1'b1; tick(); start = 1'b0;
        check_a("halt0.e0", 1'b0, 8'h00, 1'b1, 1'b0, 4'd0);
        tick();
        check_a("halt0.e1", 1'b0, 8'h00, 1'b0, 1'b1, 4'd0);
        tick();
        check_a("halt0.e2", 1'b0, 8'h00, 1'b0, 1'b1, 4'd0);

        // Full memory, DIV=1: 16 back-to-back issues, then done with pc wrapped
        do_reset();
        for (int k = 0; k < 16; k++) write_mem(4'(k), 8'(8'h20 + k));
        start = 1'b1; tick(); start = 1'b0;
        check("full.e0_valid", 32'(valid_b), 32'd0);
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("full.issue%0d.valid", k), 32'(valid_b), 32'd1);
            check($sformatf("full.issue%0d.instr", k), 32'(instr_b), 32'(8'h20 + k));
        end
        check("full.done", 32'(done_b), 32'd1);
        check("full.pc",   32'(pc_b),   32'd0);
        check("full.busy", 32'(busy_b), 32'd0);
        tick();
        check("full.after_valid", 32'(valid_b), 32'd0);
        check("full.after_instr", 32'(instr_b), 32'h2F);
        check("full.after_done",  32'(done_b),  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter Taminstr, default 8, giving the instruction word width.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the number of program memory entries; PW = log2(DEPTH).
REQ-003 The block SHALL have parameter DIV, default 4, giving the clock cycles between issues in free-run; legal range is 1..255.
REQ-004 The block SHALL have parameter HALT_WORD, default 8'hFF, which is the end-of-program marker.
REQ-005 The block SHALL have port clk  input  1  with the single clock; all logic is rising-edge triggered.
REQ-006 The block SHALL have port reset  input  1  as the reset; reset is asynchronous and active-low.
REQ-007 The block SHALL have port wr_en  input  1  as the program memory write strobe.
REQ-008 The block SHALL have port wr_addr  input  PW  as the program memory write address.
REQ-009 The block SHALL have port wr_data  input  Taminstr  as the program memory write data.
REQ-010 The block SHALL have port start  input  1  as the run request, a 1-cycle pulse.
REQ-011 The block SHALL have port step_mode  input  1  which, when 1, makes each issue wait for step.
REQ-012 The block SHALL have port step  input  1  as the single-step advance pulse.
REQ-013 The block SHALL have port instrucciones  output  Taminstr  as the issued word, registered, driven to the ALU instruction input.
REQ-014 The block SHALL have port instr_valid  output  1  which is high for exactly 1 cycle per issue.
REQ-015 The block SHALL have ports pc  output  PW  (address of the next word to fetch), busy  output  1, and done  output  1.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT, PAUSE and DONE.
REQ-017 Program memory writes SHALL take effect only in IDLE or DONE, with mem[wr_addr] <= wr_data on a clk edge where wr_en=1; writes in the other states SHALL be ignored.
REQ-018 In IDLE or DONE, start=1 SHALL set pc <= 0, clear done and move to ISSUE on the next edge.
REQ-019 If start and wr_en are both high in the same cycle, the write SHALL complete and the start SHALL also be taken.
REQ-020 In ISSUE, if mem[pc] != HALT_WORD, the block SHALL set instrucciones <= mem[pc], instr_valid <= 1 and pc <= pc+1.
REQ-021 After a non-halt issue the block SHALL go to PAUSE if step_mode=1, otherwise to WAIT.
REQ-022 In ISSUE, if mem[pc] == HALT_WORD, the block SHALL NOT issue, SHALL leave instrucciones unchanged, SHALL set done <= 1 and SHALL go to DONE.
REQ-023 After the issue from address DEPTH-1 the block SHALL go to DONE instead of WAIT or PAUSE, with done=1 and pc wrapping to 0; there is no implicit loop.
REQ-024 In WAIT, a down-counter loaded with DIV-1 at issue SHALL return the FSM to ISSUE when it reaches 0.
REQ-025 With DIV=1 there SHALL be no WAIT cycle, giving back-to-back issues.
REQ-026 In free-run the issue period SHALL be exactly DIV cycles.
REQ-027 In PAUSE, step=1 SHALL move the FSM to ISSUE, so the next instr_valid appears 2 cycles after step; step outside PAUSE SHALL be ignored.
REQ-028 If step_mode is cleared while in PAUSE, the FSM SHALL move to ISSUE on the next edge.
REQ-029 instrucciones SHALL hold the last issued word between issues and in DONE, because the ALU samples it as a level.
REQ-030 busy SHALL be 1 in ISSUE, WAIT and PAUSE, and 0 in IDLE and DONE.
REQ-031 start while busy=1 SHALL be ignored.
REQ-032 done SHALL stay 1 until the next accepted start or a reset.

Reset
REQ-033 Asserting reset low SHALL at once force the FSM to IDLE, pc=0, instrucciones=0, instr_valid=0, busy=0, done=0 and the wait counter=0, including mid-operation.
REQ-034 Program memory contents SHALL NOT be cleared by reset.
REQ-035 After reset deasserts, the first issue SHALL happen only after a start.

Verification
REQ-036 Load mem[0..2]=8'h12,8'h34,8'h56 and mem[3]=8'hFF, DIV=4, step_mode=0, start -> issues 12,34,56 with instr_valid 4 cycles apart, then done=1, busy=0, instrucciones holds 8'h56.
REQ-037 Fill all 16 entries with non-halt words, DIV=1, start -> 16 consecutive instr_valid cycles, then done=1 and pc=0.
REQ-038 step_mode=1 with the program from REQ-036, start -> one issue of 12 then the FSM holds in PAUSE; each step pulse -> next word 2 cycles later; no issue without step.
REQ-039 Pull reset low during WAIT after the second issue -> all outputs 0 at once; then start -> program reruns from mem[0] with unchanged contents.
REQ-040 wr_en to mem[0] while busy -> mem unchanged; start while busy -> ignored; start together with a write in DONE -> write lands and the run starts at pc=0.
REQ-041 mem[0]=8'hFF, start -> no instr_valid; done=1 two cycles after start; instrucciones stays 0.
